// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator with a 2-entry (main + skid) valid/ready output stage.
// Latency 1 cycle from acceptance; in_ready drops only when both entries are full.
module imm_gen_pipe #(
  parameter int I_WIDTH = 32,
  parameter int D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [I_WIDTH-1:0] instr,
  input  logic [2:0]         immsrc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_WIDTH-1:0] immop,
  output logic               illegal
);

  localparam int SHW = (D_WIDTH == 64) ? 6 : 5;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [D_WIDTH-1:0] dec_imm;
  logic               dec_ill;
  logic [D_WIDTH-1:0] skid_imm;
  logic               skid_ill;
  logic               acc;
  logic               xfer;
  logic               ld_main;
  logic               ld_main_skid;
  logic               ld_skid;
  logic               unused_opcode;

  assign unused_opcode = ^instr[6:0];

  always_comb begin
    dec_imm = '0;
    dec_ill = 1'b0;
    case (immsrc)
      3'b000:  dec_imm = D_WIDTH'($signed(instr[31:20]));
      3'b001:  dec_imm = D_WIDTH'($signed({instr[31:25], instr[11:7]}));
      3'b010:  dec_imm = D_WIDTH'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      3'b011:  dec_imm = D_WIDTH'($signed({instr[31:12], 12'h000}));
      3'b100:  dec_imm = D_WIDTH'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      3'b101:  dec_imm = D_WIDTH'(instr[20 +: SHW]);
      default: dec_ill = 1'b1;
    endcase
  end

  assign acc  = in_valid && in_ready;
  assign xfer = out_valid && out_ready;

  always_comb begin
    state_nxt    = state;
    ld_main      = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (acc) begin
          state_nxt = ST_ONE;
          ld_main   = 1'b1;
        end
      end
      ST_ONE: begin
        if (acc && xfer) begin
          ld_main = 1'b1;
        end else if (acc) begin
          state_nxt = ST_TWO;
          ld_skid   = 1'b1;
        end else if (xfer) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // in_ready is low here, so only the drain path matters
        if (xfer) begin
          state_nxt    = ST_ONE;
          ld_main_skid = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt != ST_EMPTY);
      in_ready  <= (state_nxt != ST_TWO);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      immop    <= '0;
      illegal  <= 1'b0;
      skid_imm <= '0;
      skid_ill <= 1'b0;
    end else begin
      if (ld_main) begin
        immop   <= dec_imm;
        illegal <= dec_ill;
      end else if (ld_main_skid) begin
        immop   <= skid_imm;
        illegal <= skid_ill;
      end
      if (ld_skid) begin
        skid_imm <= dec_imm;
        skid_ill <= dec_ill;
      end
    end
  end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter I_WIDTH, default 32, instruction width; only 32 is legal.
REQ-002 SHALL have parameter D_WIDTH, default 32, immediate width; legal values are 32 and 64.
REQ-003 SHALL have port clk, input, 1 bit, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1 bit, upstream presents instr/immsrc.
REQ-006 SHALL have port in_ready, output, 1 bit, block can accept; registered.
REQ-007 SHALL have port instr, input, I_WIDTH bits, instruction word.
REQ-008 SHALL have port immsrc, input, 3 bits, format: 000 I, 001 S, 010 B, 011 U, 100 J, 101 SHAMT, 110/111 illegal.
REQ-009 SHALL have port out_valid, output, 1 bit, immop/illegal are valid.
REQ-010 SHALL have port out_ready, input, 1 bit, downstream accepts.
REQ-011 SHALL have port immop, output, D_WIDTH bits, extended immediate.
REQ-012 SHALL have port illegal, output, 1 bit, the returned entry used an illegal immsrc.

Function
REQ-013 Transfer in occurs on in_valid&&in_ready; transfer out occurs on out_valid&&out_ready.
REQ-014 Immediates SHALL be sign-extended from instr[31] to D_WIDTH:
- I = instr[31:20]
- S = {instr[31:25],instr[11:7]}
- B = {instr[31],instr[7],instr[30:25],instr[11:8],0}
- U = {instr[31:12],12'h0}
- J = {instr[31],instr[19:12],instr[20],instr[30:21],0}
REQ-015 SHAMT SHALL be zero-extended: instr[24:20] when D_WIDTH=32, instr[25:20] when D_WIDTH=64.
REQ-016 Illegal immsrc SHALL produce immop=0 and illegal=1; legal formats SHALL produce illegal=0.
REQ-017 Decode SHALL be registered at input acceptance; latency SHALL be exactly 1 cycle from acceptance to out_valid when the output stage is empty.
REQ-018 Storage SHALL be a main output register plus one skid register; capacity SHALL be 2 entries.
REQ-019 State machine SHALL have three states:
- EMPTY: out_valid=0, in_ready=1.
- ONE: main register full, out_valid=1, in_ready=1.
- TWO: main and skid registers full, out_valid=1, in_ready=0.
REQ-020 EMPTY SHALL go to ONE on acceptance.
REQ-021 ONE SHALL go to:
- TWO on acceptance without output transfer;
- EMPTY on output transfer without acceptance;
- stay ONE on both, loading the new entry into main.
REQ-022 TWO SHALL go to ONE on output transfer, moving skid into main in the same edge.
REQ-023 In TWO, in_valid SHALL be ignored; no entry SHALL be accepted.
REQ-024 Entries SHALL leave in acceptance order; none SHALL be dropped or duplicated.
REQ-025 immop/illegal SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 in_ready SHALL depend only on registered state, never combinationally on out_ready.
REQ-027 Sustained in_valid=1 and out_ready=1 SHALL give throughput of one entry per cycle.

Reset
REQ-028 rst_n=0 SHALL immediately, without waiting for clk:
- set state EMPTY;
- set out_valid=0, in_ready=1, immop=0, illegal=0;
- discard both stored entries.
REQ-029 Reset asserted mid-transfer SHALL discard in-flight entries; the first edge after rst_n=1 SHALL be able to accept.

Verification
REQ-030 D32, immsrc=000, instr=0xFFF00093, out_ready=1 -> next cycle out_valid=1, immop=0xFFFFFFFF, illegal=0.
REQ-031 D32 consecutive entries with out_ready=1, one output per cycle:
- 010, 0xFE000EE3 -> immop=0xFFFFFFFC
- 011, 0x123450B7 -> immop=0x12345000
- 100, 0x0080006F -> immop=0x00000008
REQ-032 D64:
- 000, 0xFFF00093 -> immop=0xFFFFFFFFFFFFFFFF
- 101, 0x03F01093 -> immop=0x000000000000003F
REQ-033 immsrc=110, any instr -> immop=0, illegal=1.
REQ-034 Backpressure: in_valid=1 streaming 5 distinct entries, out_ready=0 for 4 cycles then 1:
- in_ready=0 after 2 acceptances;
- immop stable while stalled;
- all 5 emerge in order, none lost.
REQ-035 Reset mid-stream in state TWO -> out_valid=0 and in_ready=1 asynchronously; pre-reset entries never appear.
